// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder with a small RW register file; register 0 is also exported on reg0_q.
// Write (AW/W/B) and read (AR/R) paths are independent two-state FSMs, one transaction in flight each.
module axi4lite_slave_regs #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   reg0_q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                  r_active;
  logic                  r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_commit, w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_waddr_ok, w_raddr_ok;
  logic [DATA_WIDTH-1:0] w_rd_val;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_active <= 1'b0;
    else     r_active <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready      = 1'b0;
    wready       = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready  = r_active && !r_aw_held;
        wready   = r_active && !r_w_held;
        w_commit = (r_aw_held || (awvalid && awready)) && (r_w_held || (wvalid && wready));
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: if (bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Held values win over the bus; the bus value is only used on its own handshake edge.
  assign w_waddr    = r_aw_held ? r_awaddr : awaddr;
  assign w_wdata    = r_w_held  ? r_wdata  : wdata;
  assign w_wstrb    = r_w_held  ? r_wstrb  : wstrb;
  assign w_waddr_ok = 32'(w_waddr) < NUM_REGS;
  assign w_raddr_ok = 32'(araddr) < NUM_REGS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= w_waddr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_waddr == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
          end
        end
      end
    end else begin
      if (awvalid && awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (wvalid && wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == ADDR_WIDTH'(i)) w_rd_val = r_regs[i];
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready      = 1'b0;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready = r_active;
        w_ar_hs = arvalid && arready;
        if (w_ar_hs) w_rstate_nxt = R_RESP;
      end
      R_RESP: if (rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Capturing from r_regs before the write lands gives the pre-write value on a same-edge hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_val;
      r_rresp <= w_raddr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bvalid = (r_wstate == W_RESP);
  assign bresp  = r_bresp;
  assign rvalid = (r_rstate == R_RESP);
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign reg0_q = r_regs[0];

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: directed scenarios plus randomized traffic
// compared against a simple array model of the register file.
module tb_axi4lite_slave_regs;

  logic       clk, rst;
  logic [1:0] awaddr, araddr;
  logic       awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0] wdata, rdata, reg0_q;
  logic [0:0] wstrb;
  logic [1:0] bresp, rresp;
  logic       arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [3];

  axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(3)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg0_q(reg0_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_resp(input int a);
    return (a < 3) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [7:0] exp_read(input int a);
    return (a < 3) ? model[a] : 8'h00;
  endfunction

  task automatic model_write(input int a, input logic [7:0] d, input logic s);
    if (a < 3 && s) model[a] = d;
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                             output logic [1:0] resp, output int lat, output logic [7:0] r0);
    bit aw_done, w_done;
    resp = 2'bxx; r0 = 8'hxx; lat = -1;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    aw_done = 0; w_done = 0;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
    end
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin lat = i; resp = bresp; r0 = reg0_q; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_read(input logic [1:0] a, output logic [7:0] d,
                            output logic [1:0] resp, output int lat);
    bit done;
    d = 8'hxx; resp = 2'bxx; lat = -1;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; rready = 1; done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin lat = i; d = rdata; resp = rresp; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    for (int i = 0; i < 3; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
        rresp !== 2'b00 || rdata !== 8'h00 || reg0_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: aw/w/ar/b/r=%b%b%b%b%b bresp=%b rresp=%b rdata=%h reg0=%h, required all zero",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg0_q);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL readies_after_reset: aw/w/ar=%b%b%b, required 111", awready, wready, arready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [7:0] d, r0; int lat;
    drive_write(2'd2, 8'h04, 1'b1, resp, lat, r0);
    model_write(2, 8'h04, 1'b1);
    checks++;
    if (lat !== 0 || resp !== 2'b00) begin
      errors++;
      $display("FAIL basic_write: lat=%0d bresp=%b, required lat=0 bresp=00", lat, resp);
    end
    drive_read(2'd2, d, resp, lat);
    checks++;
    if (lat !== 0 || d !== 8'h04 || resp !== 2'b00) begin
      errors++;
      $display("FAIL basic_read: lat=%0d rdata=%h rresp=%b, required lat=0 rdata=04 rresp=00", lat, d, resp);
    end
  endtask

  task automatic test_aw_first();
    logic [1:0] resp; logic [7:0] d; int lat;
    @(posedge clk); #1;
    awaddr = 2'd1; awvalid = 1; bready = 1;
    @(posedge clk); #1;
    awvalid = 0;
    @(negedge clk);
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL aw_held: awready=%b wready=%b bvalid=%b, required 0 1 0", awready, wready, bvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    wdata = 8'hA5; wstrb = 1; wvalid = 1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL aw_first_early_b: bvalid=%b, required 0", bvalid);
    end
    @(posedge clk); #1;
    wvalid = 0;
    model_write(1, 8'hA5, 1'b1);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL aw_first_b: bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
    end
    @(posedge clk); #1;
    drive_read(2'd1, d, resp, lat);
    checks++;
    if (d !== exp_read(1) || resp !== 2'b00) begin
      errors++;
      $display("FAIL aw_first_read: rdata=%h rresp=%b, required %h 00", d, resp, exp_read(1));
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [7:0] d, r0; int lat;
    drive_write(2'd3, 8'hFF, 1'b1, resp, lat, r0);
    model_write(3, 8'hFF, 1'b1);
    checks++;
    if (resp !== exp_resp(3)) begin
      errors++;
      $display("FAIL slverr_bresp: bresp=%b, required %b", resp, exp_resp(3));
    end
    drive_read(2'd3, d, resp, lat);
    checks++;
    if (d !== 8'h00 || resp !== 2'b10) begin
      errors++;
      $display("FAIL slverr_read: rdata=%h rresp=%b, required 00 10", d, resp);
    end
    for (int i = 0; i < 3; i++) begin
      drive_read(2'(i), d, resp, lat);
      checks++;
      if (d !== exp_read(i) || resp !== 2'b00) begin
        errors++;
        $display("FAIL slverr_regs_unchanged[%0d]: rdata=%h rresp=%b, required %h 00", i, d, resp, exp_read(i));
      end
    end
  endtask

  task automatic test_wstrb0();
    logic [1:0] resp; logic [7:0] r0; int lat;
    drive_write(2'd0, 8'h3C, 1'b0, resp, lat, r0);
    model_write(0, 8'h3C, 1'b0);
    checks++;
    if (resp !== 2'b00 || r0 !== 8'h00 || reg0_q !== 8'h00) begin
      errors++;
      $display("FAIL wstrb0: bresp=%b reg0_q=%h/%h, required 00 00", resp, r0, reg0_q);
    end
    drive_write(2'd0, 8'h3C, 1'b1, resp, lat, r0);
    model_write(0, 8'h3C, 1'b1);
    checks++;
    if (resp !== 2'b00 || r0 !== model[0]) begin
      errors++;
      $display("FAIL wstrb1_reg0: bresp=%b reg0_q=%h, required 00 %h", resp, r0, model[0]);
    end
  endtask

  task automatic test_same_edge();
    logic [1:0] resp; logic [7:0] d, prior; int lat;
    prior = exp_read(1);
    @(posedge clk); #1;
    awaddr = 2'd1; wdata = 8'h11; wstrb = 1; awvalid = 1; wvalid = 1;
    araddr = 2'd1; arvalid = 1; bready = 1; rready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(1, 8'h11, 1'b1);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== prior || rresp !== 2'b00) begin
      errors++;
      $display("FAIL same_edge: bvalid=%b rvalid=%b rdata=%h rresp=%b, required 1 1 %h 00",
               bvalid, rvalid, rdata, rresp, prior);
    end
    @(posedge clk); #1;
    drive_read(2'd1, d, resp, lat);
    checks++;
    if (d !== exp_read(1)) begin
      errors++;
      $display("FAIL same_edge_followup: rdata=%h, required %h", d, exp_read(1));
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp; logic [7:0] d; int lat;
    bit stable;
    @(posedge clk); #1;
    bready = 0;
    awaddr = 2'd2; wdata = 8'hC3; wstrb = 1; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    awaddr = 2'd2;
    model_write(2, 8'hC3, 1'b1);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) stable = 0;
      @(posedge clk); #1;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bready_stall: bvalid=%b bresp=%b awready=%b wready=%b, required 1 00 0 0",
               bvalid, bresp, awready, wready);
    end
    bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: bvalid=%b awready=%b, required 0 1", bvalid, awready);
    end
    @(posedge clk); #1;
    awvalid = 0;
    wdata = 8'h5A; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    model_write(2, 8'h5A, 1'b1);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL second_write_b: bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
    end
    @(posedge clk); #1;
    drive_read(2'd2, d, resp, lat);
    checks++;
    if (d !== exp_read(2)) begin
      errors++;
      $display("FAIL second_write_read: rdata=%h, required %h", d, exp_read(2));
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(posedge clk); #1;
    araddr = 2'($urandom_range(0, 3)); arvalid = 1; rready = 1; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rvalid && rready) cnt++;
    end
    arvalid = 0;
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL read_throughput: %0d responses in 6 cycles, required 3", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [1:0] a, resp; logic [7:0] d, r0; logic s; int lat;
    for (int n = 0; n < 40; n++) begin
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom); s = 1'($urandom_range(0, 1));
        drive_write(a, d, s, resp, lat, r0);
        model_write(int'(a), d, s);
        checks++;
        if (lat !== 0 || resp !== exp_resp(int'(a)) || r0 !== model[0]) begin
          errors++;
          $display("FAIL rand_write[%0d]: addr=%0d lat=%0d bresp=%b reg0=%h, required lat=0 %b %h",
                   n, a, lat, resp, r0, exp_resp(int'(a)), model[0]);
        end
      end else begin
        drive_read(a, d, resp, lat);
        checks++;
        if (lat !== 0 || d !== exp_read(int'(a)) || resp !== exp_resp(int'(a))) begin
          errors++;
          $display("FAIL rand_read[%0d]: addr=%0d lat=%0d rdata=%h rresp=%b, required lat=0 %h %b",
                   n, a, lat, d, resp, exp_read(int'(a)), exp_resp(int'(a)));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [7:0] d; int lat;
    @(posedge clk); #1;
    awaddr = 2'd0; wdata = 8'h77; wstrb = 1; awvalid = 1; wvalid = 1;
    araddr = 2'd1; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: bvalid=%b rvalid=%b, required 1 1", bvalid, rvalid);
    end
    rst = 1;
    #1;
    for (int i = 0; i < 3; i++) model[i] = 8'h00;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || {awready, wready, arready} !== 3'b0 || reg0_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: bvalid=%b rvalid=%b readies=%b%b%b reg0=%h, required all zero",
               bvalid, rvalid, awready, wready, arready, reg0_q);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 0; bready = 1; rready = 1;
    for (int i = 0; i < 3; i++) begin
      drive_read(2'(i), d, resp, lat);
      checks++;
      if (lat !== 0 || d !== exp_read(i)) begin
        errors++;
        $display("FAIL post_reset_read[%0d]: lat=%0d rdata=%h, required lat=0 %h", i, lat, d, exp_read(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_first();
    test_slverr();
    test_wstrb0();
    test_same_edge();
    test_bready_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
